keypad_scan: RTL and testbench
==============================

# keypad_scan

Matrix-keypad scanner and debouncer for the calculator's operand and operator entry; it is the input-side counterpart of the multiplexed seven-segment display driver. The block drives a 4x4 keypad one column at a time with active-low one-cold select lines, the same rotation the display uses for its digit enables. It samples the four active-low row lines, debounces the first detected key, and presents a 4-bit key code with a one-cycle valid strobe to the ALU front end.

## Interface
- SCAN_TICKS, 100000: clk cycles per scan tick (1 ms at 100 MHz); minimum 2.
- DEBOUNCE_TICKS, 20: consecutive stable ticks required to accept a press or a release; minimum 1.
- REPEAT_TICKS, 500: held ticks between auto-repeat strobes; used only with auto-repeat enabled.
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- row_n  input  4  keypad rows, active-low, externally pulled up, asynchronous to clk.
- col_n  output  4  column select, active-low, one-cold.
- key_code  output  4  last accepted key, {row_idx[1:0], col_idx[1:0]}.
- key_valid  output  1  one-cycle strobe; key_code is valid in the same cycle.
- key_down  output  1  high while an accepted key is held (press accepted, release not yet accepted).

## Operation
- row_n passes through a 2-flop synchronizer. All decisions use the synchronized value rs_n.
- A prescaler counts 0..SCAN_TICKS-1 and emits a one-cycle tick at SCAN_TICKS-1, then wraps to 0.
- Column index c maps to col_n as follows: 0 gives 0111, 1 gives 1011, 2 gives 1101, 3 gives 1110. After 3 the index wraps to 0.
- States: SCAN, DEBOUNCE, HELD, RELEASE.
- SCAN:
  - On a tick with rs_n == 1111, advance c.
  - On a tick with any row low, capture r = the lowest-indexed low row, freeze c, clear cnt to 1, and go to DEBOUNCE.
- DEBOUNCE:
  - On a tick where row r is still low, increment cnt.
  - When cnt reaches DEBOUNCE_TICKS, latch key_code = {r, c}, pulse key_valid, set key_down, and go to HELD.
  - On a tick where row r is high, go to SCAN without a pulse. c then advances on the next tick with no press.
  - If DEBOUNCE_TICKS = 1, acceptance happens on the detection tick itself.
- HELD:
  - On a tick where row r is high, clear cnt to 1 and go to RELEASE.
  - Presses on other rows or columns are ignored.
- RELEASE:
  - On a tick where row r is high, increment cnt. At DEBOUNCE_TICKS, clear key_down and go to SCAN.
  - On a tick where row r is low, return to HELD.
- key_code holds its value until the next accepted press.
- Counters are wide enough for their parameter. Comparisons are equality against the parameter value.

## Timing
- Reset values: col_n = 0111, key_code = 0000, key_valid = 0, key_down = 0, state SCAN, prescaler 0, cnt 0.
- Reset asynchronously forces these values from any state, including mid-debounce and HELD.
- Synchronizer latency is 2 cycles. A row change is only observed at the next tick after that.
- key_valid and key_down rise on the cycle after the accepting tick. key_valid lasts exactly one cycle.
- key_down falls on the cycle after the tick that completes release debounce.
- col_n changes only in the cycle after a tick. It is stable for a full SCAN_TICKS period before it is sampled.
- A tick and a state change never occur together, so there are no simultaneous-event conflicts.

## Configuration
- KEYPAD_REPEAT_EN defined:
  - In HELD, a repeat counter increments on each tick with row r low.
  - When it reaches REPEAT_TICKS, key_valid pulses again with the unchanged key_code and the counter clears.
  - Entering HELD or RELEASE clears the counter.
- KEYPAD_REPEAT_EN undefined: there is exactly one key_valid per accepted press, and the repeat counter is not built.

## Test plan
Bench parameters: SCAN_TICKS=4, DEBOUNCE_TICKS=3, REPEAT_TICKS=5.
- Reset asserted mid-scan, then released -> col_n=0111, key_code=0000, key_valid=0, key_down=0; col_n then steps 1011, 1101, 1110, 0111 every 4 cycles.
- Row 2 held low while c=1 for 10 ticks, then released -> exactly one key_valid with key_code=1001; key_down high until 3 high ticks after release.
- Row 0 low in c=2 for 2 ticks, then high -> no key_valid, key_down stays 0, scanning resumes at c=3.
- Rows 1 and 3 low together in c=0 -> key_code=0100, one pulse.
- Key held 20 ticks -> KEYPAD_REPEAT_EN defined: 4 pulses (accept plus 3 repeats), all with the same code; undefined: 1 pulse.
- Reset asserted during HELD -> outputs return to reset values immediately; with the key still held after reset release, the key is re-detected and re-debounced.

Source files
------------

// File: rtl/keypad_scan_if.sv
// keypad_scan_if: keypad matrix lines plus the key-code output towards the ALU front end.
// master = scanner (drives columns and key outputs), slave = keypad/consumer side.
interface keypad_scan_if;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_down;

    modport master (
        input  row_n,
        output col_n, key_code, key_valid, key_down
    );

    modport slave (
        output row_n,
        input  col_n, key_code, key_valid, key_down
    );
endinterface

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner and debouncer.
// Walks a one-cold active-low column select, debounces the first key seen,
// and emits {row, col} with a one-cycle key_valid strobe.
// Optional feature: define KEYPAD_REPEAT_EN for auto-repeat strobes while a key is held.
module keypad_scan #(
    parameter int SCAN_TICKS     = 100000,
    parameter int DEBOUNCE_TICKS = 20,
    parameter int REPEAT_TICKS   = 500
) (
    input  logic          clk,
    input  logic          reset,
    keypad_scan_if.master kp
);
    localparam int PW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
    localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_TICKS - 1);
    localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_TICKS - 1);

    localparam logic [1:0] ST_SCAN     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_HELD     = 2'd2;
    localparam logic [1:0] ST_RELEASE  = 2'd3;

    // Reject parameter values below their usable minimum at elaboration.
    if (SCAN_TICKS < 2 || DEBOUNCE_TICKS < 1 || REPEAT_TICKS < 1) begin : g_bad_param
        $error("keypad_scan: parameter below minimum");
    end

    logic [3:0]    rs1, rs_n;
    logic [PW-1:0] pre;
    logic          tick;
    logic [1:0]    state;
    logic [1:0]    c, r, det_r;
    logic [CW-1:0] cnt;
    logic          row_low;
    logic          rpt_hit;

    // Two-flop synchronizer; idle (all released) out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rs1  <= 4'hF;
            rs_n <= 4'hF;
        end else begin
            rs1  <= kp.row_n;
            rs_n <= rs1;
        end
    end

    // Scan-rate prescaler; tick is high for the last count of each period.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) pre <= '0;
        else       pre <= tick ? '0 : pre + 1'b1;
    end

    assign tick = (pre == PRE_LAST);

    // Lowest-indexed low row wins when several rows are pressed.
    always_comb begin
        det_r = 2'd3;
        if (!rs_n[2]) det_r = 2'd2;
        if (!rs_n[1]) det_r = 2'd1;
        if (!rs_n[0]) det_r = 2'd0;
    end

    assign row_low  = ~rs_n[r];
    assign kp.col_n = ~(4'b1000 >> c);

`ifdef KEYPAD_REPEAT_EN
    localparam int RPW = $clog2(REPEAT_TICKS + 1);
    localparam logic [RPW-1:0] RP_LAST = RPW'(REPEAT_TICKS - 1);
    logic [RPW-1:0] rpt;

    // Repeat counter runs only while held; zero in every other state so entry starts clean.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                rpt <= '0;
        else if (state != ST_HELD)                rpt <= '0;
        else if (tick && !row_low)                rpt <= '0;
        else if (tick)                            rpt <= rpt_hit ? '0 : rpt + 1'b1;
    end

    assign rpt_hit = (state == ST_HELD) && tick && row_low && (rpt == RP_LAST);
`else
    assign rpt_hit = 1'b0;
`endif

    // Scan / debounce / hold / release sequencer; all decisions happen on ticks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_SCAN;
            c            <= 2'd0;
            r            <= 2'd0;
            cnt          <= '0;
            kp.key_code  <= 4'h0;
            kp.key_valid <= 1'b0;
            kp.key_down  <= 1'b0;
        end else begin
            kp.key_valid <= rpt_hit;
            if (tick) begin
                case (state)
                    ST_SCAN: begin
                        if (&rs_n) begin
                            c <= c + 2'd1;
                        end else begin
                            r   <= det_r;
                            cnt <= CW'(1);
                            if (DEBOUNCE_TICKS == 1) begin
                                kp.key_code  <= {det_r, c};
                                kp.key_valid <= 1'b1;
                                kp.key_down  <= 1'b1;
                                state        <= ST_HELD;
                            end else begin
                                state <= ST_DEBOUNCE;
                            end
                        end
                    end
                    ST_DEBOUNCE: begin
                        if (row_low) begin
                            cnt <= cnt + 1'b1;
                            if (cnt == DB_LAST) begin
                                kp.key_code  <= {r, c};
                                kp.key_valid <= 1'b1;
                                kp.key_down  <= 1'b1;
                                state        <= ST_HELD;
                            end
                        end else begin
                            state <= ST_SCAN;
                        end
                    end
                    ST_HELD: begin
                        if (!row_low) begin
                            cnt <= CW'(1);
                            if (DEBOUNCE_TICKS == 1) begin
                                kp.key_down <= 1'b0;
                                state       <= ST_SCAN;
                            end else begin
                                state <= ST_RELEASE;
                            end
                        end
                    end
                    ST_RELEASE: begin
                        if (!row_low) begin
                            cnt <= cnt + 1'b1;
                            if (cnt == DB_LAST) begin
                                kp.key_down <= 1'b0;
                                state       <= ST_SCAN;
                            end
                        end else begin
                            state <= ST_HELD;
                        end
                    end
                    default: state <= ST_SCAN;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: directed bench for keypad_scan with SCAN_TICKS=4, DEBOUNCE_TICKS=3, REPEAT_TICKS=5.
// Rows are driven as a static level (no column gating); outputs sampled on the falling edge.
module tb_keypad_scan;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   nchk  = 0;
    int   nerr  = 0;
    int   npulse = 0;
    int   base;

    keypad_scan_if kif();

    keypad_scan #(
        .SCAN_TICKS    (4),
        .DEBOUNCE_TICKS(3),
        .REPEAT_TICKS  (5)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .kp   (kif)
    );

    always #5 clk = ~clk;

    // Count key_valid strobes; each strobe spans exactly one falling edge.
    always @(negedge clk) begin
        if (!reset && kif.key_valid) npulse++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Wait (bounded) for the column select to reach a pattern; leaves us just after a tick.
    task automatic wait_col(input logic [3:0] t);
        for (int i = 0; i < 64 && kif.col_n !== t; i++) step(1);
        chk("wait_col", kif.col_n, t);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_col"},   kif.col_n,     4'b0111);
        chk({tag, "_code"},  kif.key_code,  4'h0);
        chk({tag, "_valid"}, kif.key_valid, 1'b0);
        chk({tag, "_down"},  kif.key_down,  1'b0);
    endtask

    initial begin
        kif.row_n = 4'hF;
        step(2);
        reset = 1'b0;

        // Reset mid-scan, then column rotation
        step(6);
        chk("pre_rst_col", kif.col_n, 4'b1011);
        #2 reset = 1'b1;
        #1 chk_reset_vals("rst_scan");
        @(negedge clk) reset = 1'b0;
        step(4); chk("col1", kif.col_n, 4'b1011);
        step(4); chk("col2", kif.col_n, 4'b1101);
        step(4); chk("col3", kif.col_n, 4'b1110);
        step(4); chk("col0", kif.col_n, 4'b0111);

        // Row 2 in column 1 held 10 ticks
        wait_col(4'b1011);
        base = npulse;
        kif.row_n = 4'b1011;
        step(11); chk("r2_pre_valid", kif.key_valid, 1'b0);
        step(1);  chk("r2_valid", kif.key_valid, 1'b1);
                  chk("r2_code",  kif.key_code,  4'b1001);
                  chk("r2_down",  kif.key_down,  1'b1);
        step(1);  chk("r2_valid_end", kif.key_valid, 1'b0);
        step(27);
        kif.row_n = 4'hF;
        step(11); chk("r2_down_hold", kif.key_down, 1'b1);
        step(1);  chk("r2_down_fall", kif.key_down, 1'b0);
        chk("r2_pulses", npulse - base, 1);

        // Row 0 bounce in column 2: rejected
        wait_col(4'b1101);
        base = npulse;
        kif.row_n = 4'b1110;
        step(8);
        kif.row_n = 4'hF;
        step(4);  chk("bnc_col_frozen", kif.col_n, 4'b1101);
        step(4);  chk("bnc_col_next",   kif.col_n, 4'b1110);
        chk("bnc_pulses", npulse - base, 0);
        chk("bnc_down",   kif.key_down, 1'b0);

        // Rows 1 and 3 together in column 0: lowest row wins
        wait_col(4'b0111);
        base = npulse;
        kif.row_n = 4'b0101;
        step(20);
        kif.row_n = 4'hF;
        step(16);
        chk("multi_code",   kif.key_code, 4'b0100);
        chk("multi_pulses", npulse - base, 1);
        chk("multi_down",   kif.key_down, 1'b0);

        // Long hold (20 ticks) in column 3, row 3
        wait_col(4'b1110);
        base = npulse;
        kif.row_n = 4'b0111;
        step(80);
        kif.row_n = 4'hF;
        step(16);
        chk("long_code", kif.key_code, 4'b1111);
`ifdef KEYPAD_REPEAT_EN
        chk("long_pulses", npulse - base, 4);
`else
        chk("long_pulses", npulse - base, 1);
`endif

        // Reset during HELD, key still pressed afterwards
        wait_col(4'b1011);
        kif.row_n = 4'b1101;
        step(16);
        chk("held_down", kif.key_down, 1'b1);
        chk("held_code", kif.key_code, 4'b0101);
        #2 reset = 1'b1;
        #1 chk_reset_vals("rst_held");
        @(negedge clk) reset = 1'b0;
        step(11); chk("redet_pre_valid", kif.key_valid, 1'b0);
                  chk("redet_pre_down",  kif.key_down,  1'b0);
        step(1);  chk("redet_valid", kif.key_valid, 1'b1);
                  chk("redet_code",  kif.key_code,  4'b0100);
                  chk("redet_down",  kif.key_down,  1'b1);
        kif.row_n = 4'hF;
        step(20);
        chk("final_down", kif.key_down, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
